// File: rtl/instr_fetch_seq_pkg.sv
// Shared types, defaults and the opcode length decode for the fetch sequencer.
// The decoder imports op_len from here so both sides agree on instruction size.
package instr_fetch_seq_pkg;

  localparam int unsigned FETCH_STATE_WIDTH = 2;
  localparam int unsigned DEF_ADDR_WIDTH    = 16;
  localparam int unsigned DEF_REG_WIDTH     = 8;
  localparam int unsigned OPERAND_WIDTH     = 16;
  localparam int unsigned OPCODE_WIDTH      = 8;
  localparam int unsigned LEN_WIDTH         = 2;
  localparam logic [15:0] DEF_RESET_PC      = 16'hFFFC;

  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FS_FETCH_OP = 2'd0,
    FS_FETCH_LO = 2'd1,
    FS_FETCH_HI = 2'd2,
    FS_READY    = 2'd3
  } fetch_state_e;

  // Instruction length in bytes from the aaa_bbb_cc opcode fields.
  function automatic logic [LEN_WIDTH-1:0] op_len(input logic [OPCODE_WIDTH-1:0] op);
    logic [2:0]           aaa;
    logic [2:0]           bbb;
    logic [1:0]           cc;
    logic [LEN_WIDTH-1:0] len;
    aaa = op[7:5];
    bbb = op[4:2];
    cc  = op[1:0];
    len = 2'd1;
    case (cc)
      2'b01: len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
      2'b11: len = 2'd1;
      default: begin
        if (bbb == 3'b000) begin
          if (cc == 2'b00) begin
            if (aaa == 3'b000 || aaa == 3'b010 || aaa == 3'b011) len = 2'd1;
            else if (aaa == 3'b001)                              len = 2'd3;
            else                                                 len = 2'd2;
          end else begin
            len = 2'd2;
          end
        end else begin
          case (bbb)
            3'b001:  len = 2'd2;
            3'b010:  len = 2'd1;
            3'b011:  len = 2'd3;
            3'b100:  len = (cc == 2'b00) ? 2'd2 : 2'd1;
            3'b101:  len = 2'd2;
            3'b110:  len = 2'd1;
            default: len = 2'd3;
          endcase
        end
      end
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Memory-bus and decoder-side signals of the fetch sequencer.
// master is the sequencer view; slave is the memory/decoder/branch-unit view.
interface instr_fetch_seq_if
  import instr_fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH
);

  logic                     mem_req;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [REG_WIDTH-1:0]     mem_rdata;
  logic                     mem_ack;
  logic                     sync;
  logic                     instr_valid;
  logic                     instr_accept;
  logic [REG_WIDTH-1:0]     opcode;
  logic [OPERAND_WIDTH-1:0] operand;
  logic [LEN_WIDTH-1:0]     instr_len;
  logic [ADDR_WIDTH-1:0]    instr_pc;
  logic                     redirect;
  logic [ADDR_WIDTH-1:0]    redirect_pc;

  modport master (
    output mem_req, mem_addr, sync, instr_valid, opcode, operand, instr_len, instr_pc,
    input  mem_rdata, mem_ack, instr_accept, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, sync, instr_valid, opcode, operand, instr_len, instr_pc,
    output mem_rdata, mem_ack, instr_accept, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_seq_opcode_length_rom.sv
// Combinational opcode-to-length lookup, a thin wrapper around op_len.
module instr_fetch_seq_opcode_length_rom
  import instr_fetch_seq_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [LEN_WIDTH-1:0]    len_c
);

  assign len_c = op_len(opcode);

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: reads opcode and operand bytes at the fetch PC
// and hands the assembled instruction to the decoder with valid/accept.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           REG_WIDTH  = DEF_REG_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_seq_if.master bus
);

  fetch_state_e             state_q,    state_d;
  logic [ADDR_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic                     mem_req_q,  mem_req_d;
  logic                     sync_q,     sync_d;
  logic                     valid_q,    valid_d;
  logic [REG_WIDTH-1:0]     opcode_q,   opcode_d;
  logic [OPERAND_WIDTH-1:0] operand_q,  operand_d;
  logic [LEN_WIDTH-1:0]     len_q,      len_d;
  logic [ADDR_WIDTH-1:0]    instr_pc_q, instr_pc_d;

  logic                     fire_c;
  logic [LEN_WIDTH-1:0]     rom_len_c;
  logic [ADDR_WIDTH-1:0]    pc_inc_c;

  instr_fetch_seq_opcode_length_rom u_len_rom (
    .opcode (OPCODE_WIDTH'(bus.mem_rdata)),
    .len_c  (rom_len_c)
  );

  // Data is only taken when our own request is out; ack alone means nothing.
  assign fire_c   = mem_req_q && bus.mem_ack;
  assign pc_inc_c = fetch_pc_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    len_d      = len_q;
    instr_pc_d = instr_pc_q;

    if (bus.redirect) begin
      state_d    = FS_FETCH_OP;
      fetch_pc_d = bus.redirect_pc;
    end else begin
      case (state_q)
        FS_FETCH_OP: if (fire_c) begin
          opcode_d   = bus.mem_rdata;
          instr_pc_d = fetch_pc_q;
          operand_d  = '0;
          len_d      = rom_len_c;
          fetch_pc_d = pc_inc_c;
          state_d    = (rom_len_c == 2'd1) ? FS_READY : FS_FETCH_LO;
        end
        FS_FETCH_LO: if (fire_c) begin
          operand_d[7:0] = 8'(bus.mem_rdata);
          fetch_pc_d     = pc_inc_c;
          state_d        = (len_q == 2'd2) ? FS_READY : FS_FETCH_HI;
        end
        FS_FETCH_HI: if (fire_c) begin
          operand_d[15:8] = 8'(bus.mem_rdata);
          fetch_pc_d      = pc_inc_c;
          state_d         = FS_READY;
        end
        FS_READY: if (bus.instr_accept) begin
          state_d = FS_FETCH_OP;
        end
        default: state_d = FS_FETCH_OP;
      endcase
    end

    // Bus outputs are registered copies of what the next state will drive.
    mem_req_d  = (state_d != FS_READY);
    sync_d     = (state_d == FS_FETCH_OP);
    valid_d    = (state_d == FS_READY);
    mem_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FS_FETCH_OP;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      sync_q     <= 1'b0;
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      len_q      <= 2'd1;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      sync_q     <= sync_d;
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      len_q      <= len_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.sync        = sync_q;
  assign bus.instr_valid = valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.instr_len   = len_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a byte-array memory model.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ack;
  logic        accept;
  logic        redir;
  logic [15:0] redir_pc;
  logic [7:0]  mem [0:65535];
  logic [7:0]  rom_op;
  logic [1:0]  rom_len;
  int          checks   = 0;
  int          failures = 0;
  int          n;

  logic [7:0] rom_ops [16] = '{8'h00, 8'h20, 8'h60, 8'h0A, 8'h10, 8'h6C, 8'hB9, 8'hFF,
                               8'hA9, 8'h4C, 8'hEA, 8'h40, 8'hA2, 8'h8D, 8'h9A, 8'h91};
  logic [1:0] rom_exp [16] = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1,
                               2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};

  always #5 clk = ~clk;

  instr_fetch_seq_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus ();

  instr_fetch_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  instr_fetch_seq_opcode_length_rom u_rom (
    .opcode (rom_op),
    .len_c  (rom_len)
  );

  assign bus.mem_rdata    = mem[bus.mem_addr];
  assign bus.mem_ack      = ack;
  assign bus.instr_accept = accept;
  assign bus.redirect     = redir;
  assign bus.redirect_pc  = redir_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [15:0] a);
    redir    = 1'b1;
    redir_pc = a;
    step();
    redir    = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.instr_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h42;
    mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
    mem[16'h0300] = 8'h20; mem[16'h0301] = 8'h00; mem[16'h0302] = 8'h40;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h11;

    reset = 1'b1; ack = 1'b1; accept = 1'b1; redir = 1'b0; redir_pc = '0;
    step();
    step();
    chk("rst_valid",   32'(bus.instr_valid), 32'd0);
    chk("rst_req",     32'(bus.mem_req),     32'd0);
    chk("rst_sync",    32'(bus.sync),        32'd0);
    chk("rst_opcode",  32'(bus.opcode),      32'h0);
    chk("rst_operand", 32'(bus.operand),     32'h0);
    chk("rst_len",     32'(bus.instr_len),   32'd1);
    chk("rst_pc",      32'(bus.instr_pc),    32'h0);

    // LDA #$42 at C000, zero wait, accept held high
    reset = 1'b0;
    redirect_to(16'hC000);
    chk("s1_req",  32'(bus.mem_req),  32'd1);
    chk("s1_sync", 32'(bus.sync),     32'd1);
    chk("s1_addr", 32'(bus.mem_addr), 32'hC000);
    step();
    chk("s1_lo_sync",  32'(bus.sync),        32'd0);
    chk("s1_lo_addr",  32'(bus.mem_addr),    32'hC001);
    chk("s1_lo_valid", 32'(bus.instr_valid), 32'd0);
    step();
    chk("s1_valid",   32'(bus.instr_valid), 32'd1);
    chk("s1_opcode",  32'(bus.opcode),      32'hA9);
    chk("s1_operand", 32'(bus.operand),     32'h0042);
    chk("s1_len",     32'(bus.instr_len),   32'd2);
    chk("s1_pc",      32'(bus.instr_pc),    32'hC000);
    chk("s1_rdy_req", 32'(bus.mem_req),     32'd0);
    chk("s1_rdy_sync",32'(bus.sync),        32'd0);
    step();
    chk("s1_next_addr",  32'(bus.mem_addr),    32'hC002);
    chk("s1_next_sync",  32'(bus.sync),        32'd1);
    chk("s1_next_valid", 32'(bus.instr_valid), 32'd0);

    // Redirect in the same cycle the NOP at C002 is accepted: it is dropped
    step();
    chk("rda_valid", 32'(bus.instr_valid), 32'd1);
    chk("rda_pc",    32'(bus.instr_pc),    32'hC002);
    redirect_to(16'h0200);
    chk("rda_addr",  32'(bus.mem_addr),    32'h0200);
    chk("rda_vdrop", 32'(bus.instr_valid), 32'd0);

    // JMP $1234 then NOP
    wait_valid(n);
    chk("s2_lat",     32'(n),               32'd3);
    chk("s2_opcode",  32'(bus.opcode),      32'h4C);
    chk("s2_operand", 32'(bus.operand),     32'h1234);
    chk("s2_len",     32'(bus.instr_len),   32'd3);
    chk("s2_pc",      32'(bus.instr_pc),    32'h0200);
    step();
    chk("s2_next_addr", 32'(bus.mem_addr), 32'h0203);
    wait_valid(n);
    chk("s2b_lat",     32'(n),             32'd1);
    chk("s2b_opcode",  32'(bus.opcode),    32'hEA);
    chk("s2b_operand", 32'(bus.operand),   32'h0000);
    chk("s2b_len",     32'(bus.instr_len), 32'd1);
    chk("s2b_pc",      32'(bus.instr_pc),  32'h0203);

    // Three wait states in FETCH_LO, then decoder holds off for five cycles
    accept = 1'b0;
    redirect_to(16'hC000);
    step();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s3_stall_addr",  32'(bus.mem_addr),    32'hC001);
      chk("s3_stall_req",   32'(bus.mem_req),     32'd1);
      chk("s3_stall_valid", 32'(bus.instr_valid), 32'd0);
      step();
    end
    ack = 1'b1;
    chk("s3_hold_addr", 32'(bus.mem_addr),    32'hC001);
    chk("s3_hold_sync", 32'(bus.sync),        32'd0);
    step();
    chk("s3_valid",   32'(bus.instr_valid), 32'd1);
    chk("s3_operand", 32'(bus.operand),     32'h0042);
    chk("s3_opcode",  32'(bus.opcode),      32'hA9);
    for (int i = 0; i < 5; i++) begin
      chk("s4_valid",   32'(bus.instr_valid), 32'd1);
      chk("s4_req",     32'(bus.mem_req),     32'd0);
      chk("s4_operand", 32'(bus.operand),     32'h0042);
      chk("s4_pc",      32'(bus.instr_pc),    32'hC000);
      step();
    end
    accept = 1'b1;
    chk("s4_pre_valid", 32'(bus.instr_valid), 32'd1);
    step();
    chk("s4_post_valid", 32'(bus.instr_valid), 32'd0);
    chk("s4_post_req",   32'(bus.mem_req),     32'd1);
    chk("s4_post_addr",  32'(bus.mem_addr),    32'hC002);
    chk("s4_post_sync",  32'(bus.sync),        32'd1);

    // Redirect during FETCH_HI of JSR drops it
    redirect_to(16'h0300);
    chk("s5_op_valid", 32'(bus.instr_valid), 32'd0);
    step();
    chk("s5_lo_valid", 32'(bus.instr_valid), 32'd0);
    step();
    chk("s5_hi_addr",  32'(bus.mem_addr),    32'h0302);
    chk("s5_hi_sync",  32'(bus.sync),        32'd0);
    chk("s5_hi_valid", 32'(bus.instr_valid), 32'd0);
    redirect_to(16'h8000);
    chk("s5_addr",  32'(bus.mem_addr),    32'h8000);
    chk("s5_sync",  32'(bus.sync),        32'd1);
    chk("s5_req",   32'(bus.mem_req),     32'd1);
    chk("s5_valid", 32'(bus.instr_valid), 32'd0);
    wait_valid(n);
    chk("s5_lat",    32'(n),          32'd1);
    chk("s5_pc",     32'(bus.instr_pc), 32'h8000);
    chk("s5_opcode", 32'(bus.opcode),   32'hEA);

    // PC wrap at FFFF, then async reset mid-FETCH_LO
    redirect_to(16'hFFFF);
    wait_valid(n);
    chk("s6_lat", 32'(n),            32'd1);
    chk("s6_pc",  32'(bus.instr_pc), 32'hFFFF);
    step();
    chk("s6_wrap_addr", 32'(bus.mem_addr), 32'h0000);
    chk("s6_wrap_sync", 32'(bus.sync),     32'd1);
    step();
    chk("s6_lo_addr", 32'(bus.mem_addr), 32'h0001);
    chk("s6_lo_req",  32'(bus.mem_req),  32'd1);
    #2 reset = 1'b1;
    #1;
    chk("s6_arst_req",   32'(bus.mem_req),     32'd0);
    chk("s6_arst_sync",  32'(bus.sync),        32'd0);
    chk("s6_arst_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("s6_rel_req",  32'(bus.mem_req),  32'd1);
    chk("s6_rel_addr", 32'(bus.mem_addr), 32'hFFFC);
    chk("s6_rel_sync", 32'(bus.sync),     32'd1);

    // Async reset while an instruction is pending
    accept = 1'b0;
    redirect_to(16'hC000);
    wait_valid(n);
    chk("s7_lat", 32'(n), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("s7_arst_valid",  32'(bus.instr_valid), 32'd0);
    chk("s7_arst_opcode", 32'(bus.opcode),      32'h0);
    chk("s7_arst_len",    32'(bus.instr_len),   32'd1);
    @(negedge clk);
    reset  = 1'b0;
    accept = 1'b1;

    // Length ROM directed sweep
    for (int i = 0; i < 16; i++) begin
      rom_op = rom_ops[i];
      #1;
      chk($sformatf("rom_len_%02h", rom_op), 32'(rom_len), 32'(rom_exp[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
